// File: rtl/tt_uart_pkg.sv
// Shared types and constants for the TinyTapeout UART transmitter.
package tt_uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_e;

    localparam int DATA_BITS = 8;

    // Bit positions inside uo_out
    localparam int TX_BIT   = 0;
    localparam int BUSY_BIT = 1;
    localparam int DONE_BIT = 2;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last clock of each bit.
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart_i,
    output logic bit_end_o
);

    localparam int                CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign bit_end_o = !restart_i && (cnt_q == LAST);

    // NOTE: every variable driven in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (restart_i || bit_end_o) begin
            cnt_d = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments with an async active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/tt_um_dff_uart_tx.sv
// TinyTapeout UART transmitter (8N1, optional even parity) driven by a synchronised send request.
module tt_um_dff_uart_tx
    import tt_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4,
    parameter bit PARITY_EN    = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    state_e          state_q, state_d;
    logic            sync1_q, sync2_q, hist_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [2:0]      bit_idx_q;
    logic            parity_q;
    logic            done_q;
    logic            bit_end;
    logic            req_edge;
    logic            accept;
    logic            tx;
    logic            busy;
    logic            unused_uio;

    assign unused_uio = ^uio_in[7:1];

    // Request is an asynchronous level: two-flop synchroniser plus history flop for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            hist_q  <= 1'b0;
        end else begin
            sync1_q <= uio_in[0];
            sync2_q <= sync1_q;
            hist_q  <= sync2_q;
        end
    end

    assign req_edge = sync2_q & ~hist_q;
    assign accept   = (state_q == IDLE) && req_edge && ena;

    uart_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .restart_i(state_q == IDLE),
        .bit_end_o(bit_end)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)  state_d = START;
            START:   if (bit_end) state_d = DATA;
            DATA: begin
                if (bit_end && bit_idx_q == 3'(DATA_BITS - 1)) begin
                    state_d = PARITY_EN ? PARITY : STOP;
                end
            end
            PARITY:  if (bit_end) state_d = STOP;
            STOP:    if (bit_end) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q   <= '0;
            bit_idx_q <= '0;
            parity_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= (state_q == STOP) && bit_end;
            if (accept) begin
                shift_q   <= ui_in;
                parity_q  <= ^ui_in;
                bit_idx_q <= '0;
            end else if (state_q == DATA && bit_end) begin
                shift_q   <= shift_q >> 1;
                bit_idx_q <= bit_idx_q + 3'd1;
            end
        end
    end

    // Line level decodes straight from state so reset forces tx high without a clock.
    always_comb begin
        tx   = 1'b1;
        busy = (state_q != IDLE);
        case (state_q)
            START:   tx = 1'b0;
            DATA:    tx = shift_q[0];
            PARITY:  tx = parity_q;
            default: tx = 1'b1;
        endcase
    end

    always_comb begin
        uo_out           = '0;
        uo_out[TX_BIT]   = tx;
        uo_out[BUSY_BIT] = busy;
        uo_out[DONE_BIT] = done_q;
    end

    assign uio_out = '0;
    assign uio_oe  = '0;

endmodule

// File: tb/tb_tt_um_dff_uart_tx.sv
// Bench for tt_um_dff_uart_tx: plain and even-parity instances share stimulus, checked against a frame-level model.
module tb_tt_um_dff_uart_tx;

    localparam int CPB = 4;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic       ena    = 1'b0;
    logic [7:0] ui_in  = 8'h00;
    logic [7:0] uio_in = 8'h00;
    logic [7:0] uo0, uo1, uio_out0, uio_out1, uio_oe0, uio_oe1;

    tt_um_dff_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uo_out(uo0),
        .uio_in(uio_in), .uio_out(uio_out0), .uio_oe(uio_oe0)
    );

    tt_um_dff_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uo_out(uo1),
        .uio_in(uio_in), .uio_out(uio_out1), .uio_oe(uio_oe1)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Reference model: a frame is a list of bits, each lasting CPB clocks.
    int         cyc = 0;
    logic       s1, s2, s3;
    bit         act [2];
    int         fstart [2];
    logic [7:0] fbyte [2];
    int         frames_m [2];
    int         frames_dut [2];
    int         busy_cycles [2];
    int         done_cycles [2];
    logic       prev_busy [2];

    function automatic int flen(int i);
        return (i == 1 ? 11 : 10) * CPB;
    endfunction

    function automatic logic frame_bit(int i, int k);
        logic [7:0] b;
        b = fbyte[i];
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
        if (i == 1 && k == 9) return ^b;
        return 1'b1;
    endfunction

    function automatic logic exp_busy(int i);
        int off;
        off = cyc - fstart[i];
        return act[i] && off >= 0 && off < flen(i);
    endfunction

    function automatic logic exp_tx(int i);
        return exp_busy(i) ? frame_bit(i, (cyc - fstart[i]) / CPB) : 1'b1;
    endfunction

    function automatic logic exp_done(int i);
        return act[i] && (cyc - fstart[i] == flen(i));
    endfunction

    task automatic model_reset();
        s1 = 1'b0; s2 = 1'b0; s3 = 1'b0;
        for (int i = 0; i < 2; i++) act[i] = 1'b0;
    endtask

    task automatic model_edge();
        bit idle;
        cyc++;
        if (!rst_n) begin
            model_reset();
            return;
        end
        for (int i = 0; i < 2; i++) begin
            idle = !act[i] || (cyc - 1 >= fstart[i] + flen(i));
            if (idle && s2 && !s3 && ena) begin
                act[i]    = 1'b1;
                fstart[i] = cyc;
                fbyte[i]  = ui_in;
                frames_m[i]++;
            end
        end
        s3 = s2;
        s2 = s1;
        s1 = uio_in[0];
    endtask

    task automatic check_outputs();
        logic [7:0] uo, uout, uoe;
        for (int i = 0; i < 2; i++) begin
            uo   = (i == 1) ? uo1 : uo0;
            uout = (i == 1) ? uio_out1 : uio_out0;
            uoe  = (i == 1) ? uio_oe1 : uio_oe0;
            check($sformatf("tx%0d c%0d", i, cyc), uo[0], exp_tx(i));
            check($sformatf("busy%0d c%0d", i, cyc), uo[1], exp_busy(i));
            check($sformatf("done%0d c%0d", i, cyc), uo[2], exp_done(i));
            check($sformatf("uo_hi%0d c%0d", i, cyc), uo[7:3], 5'd0);
            check($sformatf("uio_out%0d c%0d", i, cyc), uout, 8'd0);
            check($sformatf("uio_oe%0d c%0d", i, cyc), uoe, 8'd0);
            if (uo[1] && !prev_busy[i]) frames_dut[i]++;
            if (uo[1]) busy_cycles[i]++;
            if (uo[2]) done_cycles[i]++;
            prev_busy[i] = uo[1];
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic clear_stats();
        for (int i = 0; i < 2; i++) begin
            busy_cycles[i] = 0;
            done_cycles[i] = 0;
        end
    endtask

    int f0_base, f1_base, fe;

    initial begin
        for (int i = 0; i < 2; i++) begin
            act[i] = 1'b0; fstart[i] = 0; fbyte[i] = 8'h00; frames_m[i] = 0;
            frames_dut[i] = 0; prev_busy[i] = 1'b0;
        end
        clear_stats();
        model_reset();
        #3;
        check_outputs();
        ticks(2);
        rst_n = 1'b1;
        ena   = 1'b1;
        ticks(3);

        // 1: send 0xA5, request high for 10 clocks
        clear_stats();
        ui_in = 8'hA5;
        uio_in[0] = 1'b1;
        ticks(2);
        check("t1_tx_before_fall", uo0[0], 1'b1);
        tick();
        check("t1_tx_fall_3rd", uo0[0], 1'b0);
        ticks(7);
        uio_in[0] = 1'b0;
        ticks(50);
        check("t1_busy_len", busy_cycles[0], 40);
        check("t1_done_len", done_cycles[0], 1);
        check("t1_tx_idle", uo0[0], 1'b1);

        // 2: parity frame for 0x07
        clear_stats();
        ui_in = 8'h07;
        uio_in[0] = 1'b1;
        ticks(4);
        uio_in[0] = 1'b0;
        ticks(55);
        check("t2_par_busy_len", busy_cycles[1], 44);
        check("t2_plain_busy_len", busy_cycles[0], 40);

        // 3: stuck request, then drop/re-raise inside a frame
        f0_base = frames_dut[0];
        f1_base = frames_dut[1];
        ui_in = 8'h5A;
        uio_in[0] = 1'b1;
        ticks(100);
        check("t3_stuck_frames0", frames_dut[0] - f0_base, 1);
        check("t3_stuck_frames1", frames_dut[1] - f1_base, 1);
        uio_in[0] = 1'b0;
        ticks(5);
        ui_in = 8'hC3;
        uio_in[0] = 1'b1;
        ticks(3 + 20);
        uio_in[0] = 1'b0;
        tick();
        uio_in[0] = 1'b1;
        ticks(60);
        uio_in[0] = 1'b0;
        ticks(5);
        check("t3_total_frames0", frames_dut[0] - f0_base, 2);
        check("t3_total_frames1", frames_dut[1] - f1_base, 2);

        // 4: ena gating, then ena dropped mid-frame
        f0_base = frames_dut[0];
        ena = 1'b0;
        ui_in = 8'hFF;
        uio_in[0] = 1'b1;
        ticks(6);
        check("t4_gated_tx", uo0[0], 1'b1);
        check("t4_gated_busy", uo0[1], 1'b0);
        uio_in[0] = 1'b0;
        ticks(3);
        ena = 1'b1;
        ui_in = 8'($urandom);
        uio_in[0] = 1'b1;
        ticks(5);
        ena = 1'b0;
        uio_in[0] = 1'b0;
        ticks(50);
        check("t4_frames", frames_dut[0] - f0_base, 1);
        ena = 1'b1;

        // 5: reset during DATA bit 3, then a 0x3C frame
        ui_in = 8'($urandom);
        uio_in[0] = 1'b1;
        ticks(3);
        uio_in[0] = 1'b0;
        ticks(17);
        rst_n = 1'b0;
        model_reset();
        #1;
        check("t5_rst_tx", uo0[0], 1'b1);
        check("t5_rst_busy", uo0[1], 1'b0);
        check("t5_rst_done", uo0[2], 1'b0);
        check_outputs();
        tick();
        rst_n = 1'b1;
        ticks(2);
        clear_stats();
        ui_in = 8'h3C;
        uio_in[0] = 1'b1;
        ticks(3);
        uio_in[0] = 1'b0;
        ticks(50);
        check("t5_busy_len", busy_cycles[0], 40);

        // 6: back-to-back, acceptance lands on the done cycle
        ui_in = 8'($urandom);
        uio_in[0] = 1'b1;
        ticks(3);
        fe = fstart[0] + flen(0);
        ticks(2);
        uio_in[0] = 1'b0;
        for (int k = 0; k < 100 && cyc < fe - 2; k++) tick();
        check("t6_align", cyc, fe - 2);
        ui_in = 8'($urandom);
        uio_in[0] = 1'b1;
        ticks(2);
        check("t6_done_cycle", uo0[2], 1'b1);
        check("t6_idle_gap", uo0[1], 1'b0);
        tick();
        check("t6_restart_busy", uo0[1], 1'b1);
        check("t6_restart_tx", uo0[0], 1'b0);
        uio_in[0] = 1'b0;
        ticks(50);

        // Randomised frames with random ena, pulse widths and gaps
        for (int n = 0; n < 20; n++) begin
            ui_in = 8'($urandom);
            ena = ($urandom_range(0, 3) != 0);
            uio_in[0] = 1'b1;
            ticks($urandom_range(1, 8));
            if ($urandom_range(0, 1) == 1) ena = ~ena;
            uio_in[0] = 1'b0;
            ticks($urandom_range(0, 50));
        end
        ena = 1'b1;
        ticks(60);

        for (int i = 0; i < 2; i++) begin
            check($sformatf("frames_total%0d", i), frames_dut[i], frames_m[i]);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
